// File: rtl/iob_uart_rx_fifo_pkg.sv
// Shared types and helpers for the UART receive FIFO: drain FSM encoding and
// the flow-control threshold.
package iob_uart_rx_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    GUARD = 2'd2
  } drain_state_e;

  // rts_req stays high while level is strictly below this value.
  function automatic int unsigned rts_threshold(input int unsigned depth_log2,
                                                input int unsigned headroom);
    return (32'd1 << depth_log2) - headroom;
  endfunction

endpackage

// File: rtl/iob_uart_rx_fifo_if.sv
// Core-side receive handshake plus the consumer valid/ready stream.
// The FIFO uses the slave view; the environment uses the master view.
interface iob_uart_rx_fifo_if #(
  parameter int DATA_W = 8
);
  logic              core_rx_ready;
  logic [DATA_W-1:0] core_rx_data;
  logic              core_rd_en;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;

  modport slave (
    input  core_rx_ready, core_rx_data, m_ready,
    output core_rd_en, m_valid, m_data
  );

  modport master (
    output core_rx_ready, core_rx_data, m_ready,
    input  core_rd_en, m_valid, m_data
  );
endinterface

// File: rtl/iob_uart_rx_fifo_mem.sv
// Register-array storage: synchronous write port, asynchronous read port.
// Contents are intentionally not reset.
module iob_uart_rx_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/iob_uart_rx_fifo.sv
// Drains bytes from the UART core receive register into a small FWFT FIFO and
// raises rts_req while enough free entries remain.
module iob_uart_rx_fifo
  import iob_uart_rx_fifo_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int HEADROOM   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  iob_uart_rx_fifo_if.slave     bus,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  rts_req
);

  localparam int unsigned         DEPTH     = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_L   = DEPTH[DEPTH_LOG2:0];
  localparam int unsigned         RTS_THR   = rts_threshold(DEPTH_LOG2, HEADROOM);
  localparam logic [DEPTH_LOG2:0] RTS_THR_L = RTS_THR[DEPTH_LOG2:0];

  drain_state_e            state_q, state_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     level_q, level_d;
  logic                    rts_q, rts_d;
  logic                    rd_en, push, pop;
  logic [DATA_W-1:0]       rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // GUARD gives the core one cycle to drop core_rx_ready after the pop.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (bus.core_rx_ready && !full) state_d = POP;
        POP:     state_d = GUARD;
        GUARD:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    rd_en = 1'b0;
    if (state_q == POP && !clear) rd_en = 1'b1;
  end

  assign bus.core_rd_en = rd_en;
  assign push = rd_en;
  assign pop  = !empty && bus.m_ready && !clear;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    rts_d    = level_q < RTS_THR_L;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      rts_d    = 1'b1;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rts_q    <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      rts_q    <= rts_d;
    end
  end

  iob_uart_rx_fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.core_rx_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  assign level       = level_q;
  assign empty       = (level_q == '0);
  assign full        = (level_q == DEPTH_L);
  assign rts_req     = rts_q;
  assign bus.m_valid = !empty;
  assign bus.m_data  = rdata;

endmodule

// File: tb/tb_iob_uart_rx_fifo.sv
// Directed bench for iob_uart_rx_fifo: per-cycle vector table for the single
// byte path, then hand-written fill, wrap, clear and reset sequences.
module tb_iob_uart_rx_fifo;

  typedef struct packed {
    logic       rdy;
    logic [7:0] d;
    logic       mr;
    logic       e_rd;
    logic       e_v;
    logic [7:0] e_data;
    logic [4:0] e_lvl;
    logic       e_full;
    logic       e_empty;
    logic       e_rts;
  } vec_t;

  localparam int NV = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic [4:0] level;
  logic       full, empty, rts_req;

  iob_uart_rx_fifo_if #(.DATA_W(8)) bus ();

  iob_uart_rx_fifo #(
    .DATA_W     (8),
    .DEPTH_LOG2 (4),
    .HEADROOM   (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .bus     (bus),
    .level   (level),
    .full    (full),
    .empty   (empty),
    .rts_req (rts_req)
  );

  always #5 clk = ~clk;

  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   rd_cnt;
  int   max_lvl;
  logic track_en;
  vec_t tbl [NV];
  int   idx, rc;
  bit   got, seen;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) rd_cnt <= 0;
    else if (bus.core_rd_en === 1'b1) rd_cnt <= rd_cnt + 1;
  end

  always @(negedge clk) begin
    if (!track_en) max_lvl <= 0;
    else if (int'(level) > max_lvl) max_lvl <= int'(level);
  end

  task automatic check(input string name, input int act, input int exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    bus.core_rx_ready = 1'b1;
    bus.core_rx_data  = b;
    for (int c = 0; c < 20 && !ok; c++) begin
      #2;
      if (bus.core_rd_en) ok = 1'b1;
      cyc();
    end
    bus.core_rx_ready = 1'b0;
    check("send_handshake", int'(ok), 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_level"},  int'(level), 0);
    check({tag, "_empty"},  int'(empty), 1);
    check({tag, "_full"},   int'(full), 0);
    check({tag, "_valid"},  int'(bus.m_valid), 0);
    check({tag, "_rd_en"},  int'(bus.core_rd_en), 0);
    check({tag, "_rts"},    int'(rts_req), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rdy  d      mr  rd  v   data   lvl    full empty rts
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h3C, 5'd1, 1'b0, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b1};

    track_en          = 1'b0;
    clear             = 1'b0;
    bus.core_rx_ready = 1'b0;
    bus.core_rx_data  = 8'h00;
    bus.m_ready       = 1'b0;
    rst_n             = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    cyc();

    // Single byte and pop-on-empty, one row per clock
    for (int i = 0; i < NV; i++) begin
      bus.core_rx_ready = tbl[i].rdy;
      bus.core_rx_data  = tbl[i].d;
      bus.m_ready       = tbl[i].mr;
      #2;
      check($sformatf("v%0d_rd_en", i), int'(bus.core_rd_en), int'(tbl[i].e_rd));
      check($sformatf("v%0d_valid", i), int'(bus.m_valid), int'(tbl[i].e_v));
      check($sformatf("v%0d_level", i), int'(level), int'(tbl[i].e_lvl));
      check($sformatf("v%0d_full", i),  int'(full), int'(tbl[i].e_full));
      check($sformatf("v%0d_empty", i), int'(empty), int'(tbl[i].e_empty));
      check($sformatf("v%0d_rts", i),   int'(rts_req), int'(tbl[i].e_rts));
      if (tbl[i].e_v) check($sformatf("v%0d_data", i), int'(bus.m_data), int'(tbl[i].e_data));
      cyc();
    end
    check("table_pop_count", rd_cnt, 2);

    // Fill to 16 with consumer stalled; rts_req lags level by a cycle
    bus.m_ready = 1'b0;
    for (int i = 0; i < 12; i++) send_byte(8'(i));
    check("fill12_level", int'(level), 12);
    check("rts_still_high", int'(rts_req), 1);
    cyc();
    check("rts_fell", int'(rts_req), 0);
    for (int i = 12; i < 16; i++) send_byte(8'(i));
    check("fill16_level", int'(level), 16);
    check("fill16_full", int'(full), 1);
    check("fill16_rts", int'(rts_req), 0);

    rc = rd_cnt;
    bus.core_rx_ready = 1'b1;
    bus.core_rx_data  = 8'h10;
    repeat (6) cyc();
    #1;
    check("full_no_rd_en", int'(bus.core_rd_en), 0);
    check("full_no_pop_count", rd_cnt, rc);

    idx = 0;
    bus.m_ready = 1'b1;
    for (int c = 0; c < 80 && idx < 17; c++) begin
      #1;
      seen = bus.core_rd_en;
      if (bus.m_valid) begin
        check($sformatf("drain_data%0d", idx), int'(bus.m_data), idx);
        idx++;
      end
      cyc();
      if (seen) bus.core_rx_ready = 1'b0;
    end
    bus.m_ready       = 1'b0;
    bus.core_rx_ready = 1'b0;
    check("drain_count", idx, 17);
    check("drain_one_pop", rd_cnt, rc + 1);
    check("drain_empty", int'(empty), 1);

    // Wrap: consumer ready only in POP cycles so push and pop coincide
    track_en = 1'b1;
    send_byte(8'h80);
    for (int i = 0; i < 40; i++) begin
      bus.core_rx_ready = 1'b1;
      bus.core_rx_data  = 8'(8'h81 + i);
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        #2;
        if (bus.core_rd_en) begin
          bus.m_ready = 1'b1;
          #1;
          check($sformatf("wrap_data%0d", i), int'(bus.m_data), 8'h80 + i);
          got = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.m_ready = 1'b0;
        if (got) bus.core_rx_ready = 1'b0;
      end
      check("wrap_handshake", int'(got), 1);
      check("wrap_level", int'(level), 1);
    end
    bus.m_ready = 1'b1;
    #2;
    check("wrap_last_data", int'(bus.m_data), 8'hA8);
    cyc();
    bus.m_ready = 1'b0;
    check("wrap_final_empty", int'(empty), 1);
    check("wrap_max_level", max_lvl, 1);
    track_en = 1'b0;

    // clear landing in the POP cycle with five entries queued
    for (int i = 0; i < 5; i++) send_byte(8'(8'h50 + i));
    check("clr_pre_level", int'(level), 5);
    bus.core_rx_ready = 1'b1;
    bus.core_rx_data  = 8'h55;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      #2;
      if (bus.core_rd_en) got = 1'b1;
      else cyc();
    end
    check("clr_reach_pop", int'(got), 1);
    clear = 1'b1;
    #1;
    check("clr_rd_en_suppressed", int'(bus.core_rd_en), 0);
    cyc();
    clear = 1'b0;
    bus.core_rx_ready = 1'b0;
    check("clr_level", int'(level), 0);
    check("clr_empty", int'(empty), 1);
    check("clr_rts", int'(rts_req), 1);
    check("clr_valid", int'(bus.m_valid), 0);
    bus.core_rx_ready = 1'b1;
    bus.core_rx_data  = 8'h66;
    #2;
    check("clr_idle", int'(bus.core_rd_en), 0);
    cyc();
    #2;
    check("clr_pop_next", int'(bus.core_rd_en), 1);
    cyc();
    bus.core_rx_ready = 1'b0;
    #2;
    check("clr_new_data", int'(bus.m_data), 8'h66);
    check("clr_new_level", int'(level), 1);
    bus.m_ready = 1'b1;
    cyc();
    bus.m_ready = 1'b0;
    check("clr_consumed", int'(empty), 1);

    // Asynchronous reset in the middle of a fill
    for (int i = 0; i < 7; i++) send_byte(8'(8'h70 + i));
    check("rst_pre_level", int'(level), 7);
    #3 rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    cyc();
    rst_n = 1'b1;
    send_byte(8'h77);
    #2;
    check("post_rst_valid", int'(bus.m_valid), 1);
    check("post_rst_data", int'(bus.m_data), 8'h77);
    check("post_rst_level", int'(level), 1);
    bus.m_ready = 1'b1;
    cyc();
    bus.m_ready = 1'b0;
    check("post_rst_empty", int'(empty), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
